// File: rtl/maxpool_pkg.sv
// Shared helpers for the streaming max-pool stage: counter sizing and the
// nominal sample type of the upstream BN+ReLU stage.
package maxpool_pkg;

    localparam int DEF_BW = 12;

    typedef logic [DEF_BW-1:0] sample_t;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/maxpool_ch.sv
// One channel of the max-pool: running maximum register plus comparator.
// win_max is the window maximum including the sample presented this cycle.
module maxpool_ch #(
    parameter int BW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load_first,
    input  logic [BW-1:0] sample,
    output logic [BW-1:0] win_max
);

    logic [BW-1:0] acc;

    // Strict compare: on a tie acc is kept, which is the same value anyway.
    always_comb begin
        win_max = (load_first || (sample > acc)) ? sample : acc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= win_max;
        end
    end

endmodule

// File: rtl/maxpool_fp.sv
// Streaming 1-D max-pool: one output vector per POOL_LEN valid samples,
// frames of SEQ_LEN samples pooled independently, trailing partial window dropped.
module maxpool_fp
    import maxpool_pkg::*;
#(
    parameter int NO_CH    = 10,
    parameter int BW       = 12,
    parameter int POOL_LEN = 2,
    parameter int SEQ_LEN  = 128,
    parameter int DEBUG    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld_in,
    input  logic [NO_CH-1:0][BW-1:0]  data_in,
    output logic                      vld_out,
    output logic [NO_CH-1:0][BW-1:0]  data_out
);

    localparam int WW = clog2_min1(POOL_LEN);
    localparam int SW = clog2_min1(SEQ_LEN);
    localparam logic [WW-1:0] WIN_LAST = WW'(POOL_LEN - 1);
    localparam logic [SW-1:0] SEQ_LAST = SW'(SEQ_LEN - 1);

    logic [WW-1:0]             win_cnt;
    logic [SW-1:0]             seq_cnt;
    logic                      win_first;
    logic                      win_done;
    logic                      frame_end;
    logic [NO_CH-1:0][BW-1:0]  win_max;

    assign win_first = (win_cnt == '0);
    assign win_done  = vld_in && (win_cnt == WIN_LAST);
    assign frame_end = vld_in && (seq_cnt == SEQ_LAST);

    for (genvar i = 0; i < NO_CH; i++) begin : g_ch
        maxpool_ch #(.BW(BW)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (vld_in),
            .load_first (win_first),
            .sample     (data_in[i]),
            .win_max    (win_max[i])
        );
    end

    // A frame end restarts the window too, so a partial window is simply
    // overwritten by the next frame's first sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_cnt  <= '0;
            seq_cnt  <= '0;
            vld_out  <= 1'b0;
            data_out <= '0;
        end else begin
            vld_out <= win_done;
            if (win_done) begin
                data_out <= win_max;
            end
            if (vld_in) begin
                win_cnt <= (win_done || frame_end) ? '0 : win_cnt + 1'b1;
                seq_cnt <= frame_end ? '0 : seq_cnt + 1'b1;
            end
        end
    end

    // The window position is always the frame position modulo POOL_LEN.
    if (DEBUG != 0) begin : g_debug
        always_ff @(posedge clk) begin
            if (rst) begin
                assert (int'(win_cnt) == (int'(seq_cnt) % POOL_LEN))
                    else $error("maxpool_fp: win_cnt %0d out of step with seq_cnt %0d",
                                win_cnt, seq_cnt);
            end
        end
    end

endmodule
